// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and the
// byte-count helper. Build option LSU_MISALIGN_EN is consumed by the other files.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    logic [3:0] n;
    case (sz)
      SZ_BYTE:  n = 4'd1;
      SZ_HALF:  n = 4'd2;
      SZ_WORD:  n = 4'd4;
      SZ_DWORD: n = 4'd8;
      default:  n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit: byte-enable generation,
// store data rotation into bus lanes and load assembly with zero/sign extension.
// With LSU_MISALIGN_EN defined, an access may spill into a second bus word; the
// second-beat enables/data and the upper read word are then exposed.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [$clog2(DW/8)-1:0] off,
  input  logic [1:0]              size,
  input  logic                    sgn,
  input  logic [DW-1:0]           wdata,
  input  logic [DW-1:0]           rd_lo,
`ifdef LSU_MISALIGN_EN
  input  logic [DW-1:0]           rd_hi,
  output logic [DW/8-1:0]         be1,
  output logic [DW-1:0]           wdata1,
  output logic                    cross,
`endif
  output logic [DW/8-1:0]         be0,
  output logic [DW-1:0]           wdata0,
  output logic [DW-1:0]           rdata
);

  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);

  logic [NB-1:0]      bm;
  logic [DW-1:0]      wm;
  logic [DW-1:0]      raw;
  logic [OFFW+2:0]    sh;
  logic               msb;
  logic               ext;
  int                 nbi;

  // Byte mask of the access, lane steering in both directions, then extension.
  always_comb begin
    nbi = int'(size_bytes(size));
    sh  = {off, 3'b000};
    bm  = '0;
    wm  = '0;
    for (int i = 0; i < NB; i++) begin
      bm[i]         = (i < nbi);
      wm[i*8 +: 8]  = bm[i] ? wdata[i*8 +: 8] : 8'h00;
    end
`ifdef LSU_MISALIGN_EN
    {be1, be0}       = {{NB{1'b0}}, bm} << off;
    {wdata1, wdata0} = {{DW{1'b0}}, wm} << sh;
    cross            = |be1;
    raw              = DW'({rd_hi, rd_lo} >> sh);
`else
    be0              = bm << off;
    wdata0           = wm << sh;
    raw              = rd_lo >> sh;
`endif
    // Top byte of the access decides the sign; full-width accesses never extend.
    msb = 1'b0;
    for (int i = 0; i < NB; i++)
      if (bm[i]) msb = raw[i*8 + 7];
    ext   = sgn && msb && !bm[NB-1];
    rdata = '0;
    for (int i = 0; i < NB; i++)
      rdata[i*8 +: 8] = bm[i] ? raw[i*8 +: 8] : {8{ext}};
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request handshake, one or two bus beats, and a
// one-cycle response pulse. Bus outputs are decoded from latched request state,
// so they hold steady through wait states and never depend on live inputs.
// Define LSU_MISALIGN_EN to allow unaligned accesses (split into two beats when
// they cross a bus word); otherwise unaligned accesses fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  output logic              rsp_fault,
  output logic [DW-1:0]     rsp_rdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [AW-1:0]     bus_addr,
  output logic [DW/8-1:0]   bus_be,
  output logic [DW-1:0]     bus_wdata,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [3:0]      req_nb;
  logic            req_fault;
  logic [AW-1:0]   base_addr;
  logic [NB-1:0]   al_be0;
  logic [DW-1:0]   al_wdata0;
  logic [DW-1:0]   al_rdata;
  logic [DW-1:0]   al_rd_lo;

`ifdef LSU_MISALIGN_EN
  logic [DW-1:0]   rd0_q, rd0_d;
  logic [NB-1:0]   al_be1;
  logic [DW-1:0]   al_wdata1;
  logic            al_cross;
`endif

  // Size check always applies; alignment check only when misalignment is off.
  always_comb begin
    req_nb    = size_bytes(req_size);
    req_fault = int'(req_nb) > NB;
`ifndef LSU_MISALIGN_EN
    if ((req_addr[OFFW-1:0] & OFFW'(req_nb - 4'd1)) != '0) req_fault = 1'b1;
`endif
  end

  // In BEAT1 the first beat's lanes come from the capture register.
`ifdef LSU_MISALIGN_EN
  assign al_rd_lo = (state_q == S_BEAT1) ? rd0_q : bus_rdata;
`else
  assign al_rd_lo = bus_rdata;
`endif

  lsu_lane_align #(.DW(DW)) u_align (
    .off    (addr_q[OFFW-1:0]),
    .size   (size_q),
    .sgn    (sgn_q),
    .wdata  (wdata_q),
    .rd_lo  (al_rd_lo),
`ifdef LSU_MISALIGN_EN
    .rd_hi  (bus_rdata),
    .be1    (al_be1),
    .wdata1 (al_wdata1),
    .cross  (al_cross),
`endif
    .be0    (al_be0),
    .wdata0 (al_wdata0),
    .rdata  (al_rdata)
  );

  // Next-state and response computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_EN
    rd0_d       = rd0_q;
`endif
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        sgn_d   = req_signed;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (req_fault) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
        end else begin
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: if (bus_ready) begin
`ifdef LSU_MISALIGN_EN
        rd0_d = bus_rdata;
        if (al_cross) begin
          state_d = S_BEAT1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : al_rdata;
        end
`else
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : al_rdata;
`endif
      end
`ifdef LSU_MISALIGN_EN
      S_BEAT1: if (bus_ready) begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : al_rdata;
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request/response registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
      rd0_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_EN
      rd0_q       <= rd0_d;
`endif
    end
  end

  assign base_addr = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

  // Bus beat outputs decoded from state and latched request only.
  always_comb begin
    bus_valid = 1'b0;
    bus_addr  = base_addr;
    bus_be    = '0;
    bus_wdata = '0;
    if (state_q == S_BEAT0) begin
      bus_valid = 1'b1;
      bus_be    = al_be0;
      bus_wdata = we_q ? al_wdata0 : '0;
    end
`ifdef LSU_MISALIGN_EN
    if (state_q == S_BEAT1) begin
      bus_valid = 1'b1;
      bus_addr  = base_addr + AW'(NB);
      bus_be    = al_be1;
      bus_wdata = we_q ? al_wdata1 : '0;
    end
`endif
    bus_we = bus_valid && we_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DW=32). Vector table drives single
// accesses through a bench-side bus; expected responses go to a scoreboard
// queue that a monitor drains on rsp_valid. Expectations follow LSU_MISALIGN_EN.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_fault;
  logic [DW-1:0] rsp_rdata;
  logic          bus_valid, bus_ready, bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct packed {
    logic        f;
    logic [31:0] d;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      chk("rsp_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_fault", rsp_fault, mon_e.f);
        chk("rsp_rdata", rsp_rdata, mon_e.d);
      end
    end
  end

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad, wd, rd0, rd1;
    int          waits;
    logic        flt;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                              input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int waits,
                              input logic flt, input int nb,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] w0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] w1,
                              input logic [31:0] rdata);
    vec_t v;
    v.nm = nm; v.we = we; v.sz = sz; v.sg = sg; v.ad = ad; v.wd = wd;
    v.rd0 = rd0; v.rd1 = rd1; v.waits = waits; v.flt = flt; v.nb = nb;
    v.a0 = a0; v.be0 = be0; v.w0 = w0; v.a1 = a1; v.be1 = be1; v.w1 = w1;
    v.rdata = rdata;
    return v;
  endfunction

  vec_t vt[$];

  task automatic run_vec(input vec_t v);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    chk({v.nm, ":req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_signed = v.sg;
    req_addr = v.ad; req_wdata = v.wd;
    exp_q.push_back({v.flt, v.rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (v.flt) begin
      chk({v.nm, ":no_beat"}, bus_valid, 0);
      chk({v.nm, ":fault_rsp_valid"}, rsp_valid, 1);
    end else begin
      for (int b = 0; b < v.nb; b++) begin
        ea = (b == 0) ? v.a0 : v.a1;
        eb = (b == 0) ? v.be0 : v.be1;
        ew = (b == 0) ? v.w0 : v.w1;
        for (int w = 0; w <= v.waits; w++) begin
          chk({v.nm, ":bus_valid"}, bus_valid, 1);
          chk({v.nm, ":bus_addr"}, bus_addr, ea);
          chk({v.nm, ":bus_be"}, bus_be, eb);
          chk({v.nm, ":bus_we"}, bus_we, v.we);
          if (v.we) chk({v.nm, ":bus_wdata"}, bus_wdata, ew);
          if (w == v.waits) begin
            bus_ready = 1'b1;
            bus_rdata = (b == 0) ? v.rd0 : v.rd1;
          end else begin
            bus_rdata = $urandom;
          end
          @(negedge clk);
          bus_ready = 1'b0;
          bus_rdata = $urandom;
        end
      end
      chk({v.nm, ":rsp_valid"}, rsp_valid, 1);
    end
    @(negedge clk);
    chk({v.nm, ":rsp_one_cycle"}, rsp_valid, 0);
    chk({v.nm, ":ready_again"}, req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h12345678; bus_ready = 1'b0; bus_rdata = '0;

    // Reset values; a request held during reset must not be taken.
    repeat (2) @(negedge clk);
    chk("rst:req_ready", req_ready, 1);
    chk("rst:bus_valid", bus_valid, 0);
    chk("rst:rsp_valid", rsp_valid, 0);
    chk("rst:rsp_fault", rsp_fault, 0);
    chk("rst:rsp_rdata", rsp_rdata, 0);
    chk("rst:bus_be", bus_be, 0);
    chk("rst:bus_wdata", bus_wdata, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst:idle", req_ready, 1);
    chk("post_rst:no_beat", bus_valid, 0);

    vt.push_back(mk("st_word", 1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 1,
                    32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0));
    vt.push_back(mk("st_word_stall", 1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 3, 0, 1,
                    32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0));
    vt.push_back(mk("ld_byte_s", 0, 0, 1, 32'h203, 0, 32'h80123456, 0, 0, 0, 1,
                    32'h200, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80));
    vt.push_back(mk("ld_byte_u", 0, 0, 0, 32'h203, 0, 32'h80123456, 0, 0, 0, 1,
                    32'h200, 4'h8, 0, 0, 0, 0, 32'h00000080));
    vt.push_back(mk("st_half", 1, 1, 0, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 1,
                    32'h100, 4'hC, 32'hABCD0000, 0, 0, 0, 0));
    vt.push_back(mk("ld_dword_fault", 0, 3, 0, 32'h100, 0, 0, 0, 0, 1, 0,
                    0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("ld_half_s", 0, 1, 1, 32'h106, 0, 32'h9ABC0000, 0, 1, 0, 1,
                    32'h104, 4'hC, 0, 0, 0, 0, 32'hFFFF9ABC));
    vt.push_back(mk("ld_word_s", 0, 2, 1, 32'h200, 0, 32'h80000001, 0, 0, 0, 1,
                    32'h200, 4'hF, 0, 0, 0, 0, 32'h80000001));
    vt.push_back(mk("st_byte", 1, 0, 0, 32'h101, 32'hFFFFFF5A, 0, 0, 0, 0, 1,
                    32'h100, 4'h2, 32'h00005A00, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_EN
    vt.push_back(mk("ld_half_mis", 0, 1, 0, 32'h101, 0, 32'h80123456, 0, 0, 0, 1,
                    32'h100, 4'h6, 0, 0, 0, 0, 32'h00001234));
    vt.push_back(mk("ld_word_split", 0, 2, 0, 32'h102, 0, 32'hAABBCCDD, 32'h11223344, 1, 0, 2,
                    32'h100, 4'hC, 0, 32'h104, 4'h3, 0, 32'h3344AABB));
    vt.push_back(mk("st_word_split", 1, 2, 0, 32'h102, 32'h3344AABB, 0, 0, 0, 0, 2,
                    32'h100, 4'hC, 32'hAABB0000, 32'h104, 4'h3, 32'h00003344, 0));
    vt.push_back(mk("ld_half_split_s", 0, 1, 1, 32'h103, 0, 32'h80000000, 32'h000000FF, 0, 0, 2,
                    32'h100, 4'h8, 0, 32'h104, 4'h1, 0, 32'hFFFFFF80));
    vt.push_back(mk("ld_word_wrap", 0, 2, 0, 32'hFFFFFFFE, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 2,
                    32'hFFFFFFFC, 4'hC, 0, 32'h0, 4'h3, 0, 32'hDEF01234));
`else
    vt.push_back(mk("ld_half_mis_fault", 0, 1, 0, 32'h101, 0, 0, 0, 0, 1, 0,
                    0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("ld_word_mis_fault", 0, 2, 0, 32'h102, 0, 0, 0, 0, 1, 0,
                    0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("st_word_mis_fault", 1, 2, 0, 32'h102, 32'h3344AABB, 0, 0, 0, 1, 0,
                    0, 0, 0, 0, 0, 0, 0));
`endif

    foreach (vt[i]) run_vec(vt[i]);

    // Reset while a beat is stalled: beat vanishes at once, no response follows.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
`ifdef LSU_MISALIGN_EN
    req_addr = 32'h102;
    @(negedge clk);
    req_valid = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'hAABBCCDD;
    @(negedge clk);
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid:in_beat1", bus_valid, 1);
    chk("rst_mid:beat1_addr", bus_addr, 32'h104);
`else
    req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid:in_beat0", bus_valid, 1);
    chk("rst_mid:beat0_addr", bus_addr, 32'h100);
`endif
    #2 reset = 1'b1;
    #1;
    chk("rst_mid:bus_valid_drop", bus_valid, 0);
    chk("rst_mid:no_rsp", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid:req_ready", req_ready, 1);
    chk("rst_mid:bus_idle", bus_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid:still_no_rsp", rsp_valid, 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
